// File: rtl/float_to_unsig_int_if.sv
// -----------------------------------------------------------------------------
// float_to_unsig_int_if
//
// Purpose : Bundles the operand and result handshakes of float_to_unsig_int.
//           The converter connects through the slave modport. The producer of
//           operands and consumer of results connects through the master
//           modport.
//
// Signals : input_a[31:0]      float32 operand (master -> slave)
//           input_a_stb        operand valid   (master -> slave)
//           input_a_ack        converter ready (slave -> master)
//           output_z[31:0]     unsigned result (slave -> master)
//           output_z_stb       result valid    (slave -> master)
//           output_z_ack       result consumed (master -> slave)
//           output_flags[4:0]  {NV,DZ,OF,UF,NX}, only when FTOU_FFLAGS_EN
//
// Config  : FTOU_FFLAGS_EN adds output_flags.
// -----------------------------------------------------------------------------
interface float_to_unsig_int_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
`ifdef FTOU_FFLAGS_EN
    logic [4:0]  output_flags;

    modport master (
        output input_a,
        output input_a_stb,
        input  input_a_ack,
        input  output_z,
        input  output_z_stb,
        output output_z_ack,
        input  output_flags
    );

    modport slave (
        input  input_a,
        input  input_a_stb,
        output input_a_ack,
        output output_z,
        output output_z_stb,
        input  output_z_ack,
        output output_flags
    );
`else
    modport master (
        output input_a,
        output input_a_stb,
        input  input_a_ack,
        input  output_z,
        input  output_z_stb,
        output output_z_ack
    );

    modport slave (
        input  input_a,
        input  input_a_stb,
        output input_a_ack,
        output output_z,
        output output_z_stb,
        input  output_z_ack
    );
`endif
endinterface

// File: rtl/float_to_unsig_int.sv
// -----------------------------------------------------------------------------
// float_to_unsig_int
//
// Purpose : Multi-cycle IEEE-754 single-precision to unsigned 32-bit integer
//           converter with round-toward-zero (FCVT.WU.S). One conversion is
//           in flight at a time. All outputs are registered.
//
// Ports   : clk  - clock, everything on the rising edge
//           rst  - synchronous active-high reset
//           bus  - float_to_unsig_int_if.slave:
//                  input_a / input_a_stb / input_a_ack    operand handshake
//                  output_z / output_z_stb / output_z_ack result handshake
//                  output_flags {NV,DZ,OF,UF,NX}          (FTOU_FFLAGS_EN)
//
// Config  : FTOU_FFLAGS_EN - when defined, exception flags and the sticky
//           bit are built and driven on output_flags. When undefined, that
//           logic is absent. The result value and timing are the same in
//           both builds.
//
// Flow    : GET_A -> UNPACK -> SPECIAL -> (SHIFT ...) -> PUT_Z -> GET_A
//           Special operands produce a result directly from SPECIAL. Normal
//           in-range operands are right-shifted one bit per cycle until the
//           unbiased exponent reaches 31.
// -----------------------------------------------------------------------------
module float_to_unsig_int (
    input  logic                       clk,
    input  logic                       rst,
    float_to_unsig_int_if.slave        bus
);

    localparam logic [2:0] GET_A   = 3'd0;
    localparam logic [2:0] UNPACK  = 3'd1;
    localparam logic [2:0] SPECIAL = 3'd2;
    localparam logic [2:0] SHIFT   = 3'd3;
    localparam logic [2:0] PUT_Z   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] a_q,     a_d;
    logic        s_q,     s_d;
    logic [7:0]  exp_q,   exp_d;
    logic [22:0] frac_q,  frac_d;
    logic [31:0] m_q,     m_d;
    logic [4:0]  e_q,     e_d;
    logic [31:0] z_q,     z_d;
    logic        stb_q,   stb_d;
    logic        ack_q,   ack_d;
`ifdef FTOU_FFLAGS_EN
    logic        nv_q,     nv_d;
    logic        nx_q,     nx_d;
    logic        sticky_q, sticky_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        s_d     = s_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        m_d     = m_q;
        e_d     = e_q;
        z_d     = z_q;
        stb_d   = stb_q;
        ack_d   = ack_q;
`ifdef FTOU_FFLAGS_EN
        nv_d     = nv_q;
        nx_d     = nx_q;
        sticky_d = sticky_q;
`endif

        case (state_q)
            GET_A: begin
                if (bus.input_a_stb && ack_q) begin
                    a_d     = bus.input_a;
                    ack_d   = 1'b0;
                    state_d = UNPACK;
`ifdef FTOU_FFLAGS_EN
                    // Flags from the previous result are dropped here.
                    nv_d     = 1'b0;
                    nx_d     = 1'b0;
                    sticky_d = 1'b0;
`endif
                end else begin
                    // Raising ack here gives the one-cycle gap after reset.
                    ack_d = 1'b1;
                end
            end

            UNPACK: begin
                s_d     = a_q[31];
                exp_d   = a_q[30:23];
                frac_d  = a_q[22:0];
                state_d = SPECIAL;
            end

            SPECIAL: begin
                // Priority order matters: first matching class wins.
                if (exp_q == 8'd255 && frac_q != 23'd0) begin
                    // NaN saturates high.
                    z_d     = 32'hFFFF_FFFF;
                    stb_d   = 1'b1;
                    state_d = PUT_Z;
`ifdef FTOU_FFLAGS_EN
                    nv_d = 1'b1;
`endif
                end else if (exp_q == 8'd255) begin
                    // Infinity: +inf saturates high, -inf clamps to zero.
                    z_d     = s_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
                    stb_d   = 1'b1;
                    state_d = PUT_Z;
`ifdef FTOU_FFLAGS_EN
                    nv_d = 1'b1;
`endif
                end else if (exp_q == 8'd0) begin
                    // Signed zero is exact. A denormal of either sign truncates to 0.
                    z_d     = 32'h0000_0000;
                    stb_d   = 1'b1;
                    state_d = PUT_Z;
`ifdef FTOU_FFLAGS_EN
                    nx_d = (frac_q != 23'd0);
`endif
                end else if (s_q && exp_q >= 8'd127) begin
                    // Value <= -1.0 cannot be represented as unsigned.
                    z_d     = 32'h0000_0000;
                    stb_d   = 1'b1;
                    state_d = PUT_Z;
`ifdef FTOU_FFLAGS_EN
                    nv_d = 1'b1;
`endif
                end else if (exp_q < 8'd127) begin
                    // 0 < |x| < 1 truncates to 0. This covers -1 < x < 0 too.
                    z_d     = 32'h0000_0000;
                    stb_d   = 1'b1;
                    state_d = PUT_Z;
`ifdef FTOU_FFLAGS_EN
                    nx_d = 1'b1;
`endif
                end else if (!s_q && exp_q > 8'd158) begin
                    // x >= 2^32 overflows.
                    z_d     = 32'hFFFF_FFFF;
                    stb_d   = 1'b1;
                    state_d = PUT_Z;
`ifdef FTOU_FFLAGS_EN
                    nv_d = 1'b1;
`endif
                end else begin
                    // Mantissa is MSB-aligned so that e==31 means "done".
                    m_d = {1'b1, frac_q, 8'h00};
                    // exp is in 127..158 here. Because -127 is congruent to
                    // +1 modulo 32, exp-127 equals exp[4:0]+1 in 5 bits.
                    e_d     = exp_q[4:0] + 5'd1;
                    state_d = SHIFT;
`ifdef FTOU_FFLAGS_EN
                    sticky_d = 1'b0;
`endif
                end
            end

            SHIFT: begin
                if (e_q == 5'd31) begin
                    z_d     = m_q;
                    stb_d   = 1'b1;
                    state_d = PUT_Z;
`ifdef FTOU_FFLAGS_EN
                    nx_d = sticky_q;
`endif
                end else begin
                    m_d = {1'b0, m_q[31:1]};
                    e_d = e_q + 5'd1;
`ifdef FTOU_FFLAGS_EN
                    // Any 1 shifted out means the truncation was inexact.
                    sticky_d = sticky_q | m_q[0];
`endif
                end
            end

            PUT_Z: begin
                if (bus.output_z_ack) begin
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = GET_A;
                end
            end

            default: begin
                stb_d   = 1'b0;
                ack_d   = 1'b0;
                state_d = GET_A;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= 32'd0;
            s_q     <= 1'b0;
            exp_q   <= 8'd0;
            frac_q  <= 23'd0;
            m_q     <= 32'd0;
            e_q     <= 5'd0;
            z_q     <= 32'd0;
            stb_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            s_q     <= s_d;
            exp_q   <= exp_d;
            frac_q  <= frac_d;
            m_q     <= m_d;
            e_q     <= e_d;
            z_q     <= z_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
        end
    end

`ifdef FTOU_FFLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            nv_q     <= 1'b0;
            nx_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            nv_q     <= nv_d;
            nx_q     <= nx_d;
            sticky_q <= sticky_d;
        end
    end

    // DZ, OF and UF never occur in this conversion.
    assign bus.output_flags = {nv_q, 1'b0, 1'b0, 1'b0, nx_q};
`endif

    assign bus.input_a_ack  = ack_q;
    assign bus.output_z     = z_q;
    assign bus.output_z_stb = stb_q;

endmodule

// File: tb/tb_float_to_unsig_int.sv
// -----------------------------------------------------------------------------
// tb_float_to_unsig_int
//
// Directed test of float_to_unsig_int. Each scenario task drives operands and
// compares the result, latency, handshake behaviour and (with FTOU_FFLAGS_EN)
// the exception flags against values worked out by hand.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_float_to_unsig_int;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    float_to_unsig_int_if bus();

    float_to_unsig_int dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_NV   = 5'b10000;
    localparam logic [4:0] F_NX   = 5'b00001;

    // Wait, with a bound, until the converter is ready for an operand.
    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (bus.input_a_ack !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (bus.input_a_ack !== 1'b1) begin
            n_mis++;
            $display("FAIL %s ready-timeout: input_a_ack=%b required 1", name, bus.input_a_ack);
        end
    endtask

    // Offer one operand and return once it has been accepted (edge N, +1ns).
    task automatic send(input logic [31:0] a);
        bus.input_a     = a;
        bus.input_a_stb = 1'b1;
        @(posedge clk); #1;
        bus.input_a_stb = 1'b0;
        bus.input_a     = 32'hDEAD_BEEF;
    endtask

    // Count edges after edge N until output_z_stb shows.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (bus.output_z_stb !== 1'b1 && lat < 60);
    endtask

    // One complete conversion with output_z_ack held high.
    task automatic convert(input string name, input logic [31:0] a,
                           input logic [31:0] exp_z, input int exp_lat,
                           input logic [4:0] exp_flags);
        int lat;
        bus.output_z_ack = 1'b1;
        wait_ready(name);
        send(a);
        n_cmp++;
        if (bus.input_a_ack !== 1'b0) begin
            n_mis++;
            $display("FAIL %s ack-after-accept: got %b required 0", name, bus.input_a_ack);
        end
        wait_result(lat);
        n_cmp++;
        if (bus.output_z_stb !== 1'b1 || lat != exp_lat) begin
            n_mis++;
            $display("FAIL %s latency: stb=%b after %0d edges, required stb=1 after %0d", name, bus.output_z_stb, lat, exp_lat);
        end
        n_cmp++;
        if (bus.output_z !== exp_z) begin
            n_mis++;
            $display("FAIL %s output_z: got %08h required %08h", name, bus.output_z, exp_z);
        end
`ifdef FTOU_FFLAGS_EN
        n_cmp++;
        if (bus.output_flags !== exp_flags) begin
            n_mis++;
            $display("FAIL %s flags: got %05b required %05b", name, bus.output_flags, exp_flags);
        end
`endif
        @(posedge clk); #1;
        n_cmp++;
        if (bus.output_z_stb !== 1'b0 || bus.input_a_ack !== 1'b1) begin
            n_mis++;
            $display("FAIL %s consume: stb=%b ack=%b required stb=0 ack=1", name, bus.output_z_stb, bus.input_a_ack);
        end
        $display("%-14s a=%08h z=%08h lat=%0d expected z=%08h lat=%0d flags=%05b", name, a, bus.output_z, lat, exp_z, exp_lat, exp_flags);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.input_a_ack !== 1'b0 || bus.output_z_stb !== 1'b0 || bus.output_z !== 32'd0) begin
            n_mis++;
            $display("FAIL reset-state: ack=%b stb=%b z=%08h required 0 0 00000000", bus.input_a_ack, bus.output_z_stb, bus.output_z);
        end
`ifdef FTOU_FFLAGS_EN
        n_cmp++;
        if (bus.output_flags !== 5'd0) begin
            n_mis++;
            $display("FAIL reset-flags: got %05b required 00000", bus.output_flags);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.input_a_ack !== 1'b1) begin
            n_mis++;
            $display("FAIL reset-release-ack: got %b required 1", bus.input_a_ack);
        end
        $display("reset          ack=%b stb=%b z=%08h", bus.input_a_ack, bus.output_z_stb, bus.output_z);
    endtask

    task automatic test_shifted();
        convert("two",        32'h4000_0000, 32'h0000_0002, 33, F_NONE);
        convert("max_exact",  32'h4F7F_FFFF, 32'hFFFF_FF00, 3,  F_NONE);
        convert("one_half",   32'h3FC0_0000, 32'h0000_0001, 34, F_NX);
    endtask

    task automatic test_specials();
        convert("half",       32'h3F00_0000, 32'h0000_0000, 2, F_NX);
        convert("denormal",   32'h0000_0001, 32'h0000_0000, 2, F_NX);
        convert("neg_zero",   32'h8000_0000, 32'h0000_0000, 2, F_NONE);
        convert("nan",        32'h7FC0_0000, 32'hFFFF_FFFF, 2, F_NV);
        convert("two_pow_32", 32'h4F80_0000, 32'hFFFF_FFFF, 2, F_NV);
        convert("neg_inf",    32'hFF80_0000, 32'h0000_0000, 2, F_NV);
        convert("neg_one",    32'hBF80_0000, 32'h0000_0000, 2, F_NV);
        convert("neg_half",   32'hBF00_0000, 32'h0000_0000, 2, F_NX);
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [31:0] z0;
        bus.output_z_ack = 1'b0;
        wait_ready("bp");
        send(32'h4F7F_FFFF);
        wait_result(lat);
        z0 = bus.output_z;
        n_cmp++;
        if (bus.output_z_stb !== 1'b1 || z0 !== 32'hFFFF_FF00) begin
            n_mis++;
            $display("FAIL bp-first: stb=%b z=%08h required 1 ffffff00", bus.output_z_stb, z0);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.output_z_stb !== 1'b1 || bus.output_z !== 32'hFFFF_FF00 || bus.input_a_ack !== 1'b0) begin
                n_mis++;
                $display("FAIL bp-hold%0d: stb=%b z=%08h ack=%b required 1 ffffff00 0", i, bus.output_z_stb, bus.output_z, bus.input_a_ack);
            end
        end
        bus.output_z_ack = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.output_z_stb !== 1'b0 || bus.input_a_ack !== 1'b1) begin
            n_mis++;
            $display("FAIL bp-release: stb=%b ack=%b required 0 1", bus.output_z_stb, bus.input_a_ack);
        end
        $display("backpressure   z=%08h held 5 cycles, released", z0);
        convert("three",      32'h4040_0000, 32'h0000_0003, 33, F_NONE);
    endtask

    task automatic test_reset_abort();
        bus.output_z_ack = 1'b1;
        wait_ready("abort");
        send(32'h3F80_0001);
        // Edges N+1 and N+2 reach SHIFT, then ten more shift edges.
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.output_z_stb !== 1'b0 || bus.input_a_ack !== 1'b0 || bus.output_z !== 32'd0) begin
            n_mis++;
            $display("FAIL abort-reset: stb=%b ack=%b z=%08h required 0 0 00000000", bus.output_z_stb, bus.input_a_ack, bus.output_z);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.input_a_ack !== 1'b1) begin
            n_mis++;
            $display("FAIL abort-release-ack: got %b required 1", bus.input_a_ack);
        end
        $display("abort          reset during SHIFT of 3f800001");
        convert("ten",        32'h4120_0000, 32'h0000_000A, 31, F_NONE);
    endtask

    task automatic test_round_trip();
        convert("rt_2",        32'h4000_0000, 32'h0000_0002, 33, F_NONE);
        convert("rt_ffffff",   32'h4B7F_FFFF, 32'h00FF_FFFF, 11, F_NONE);
        convert("rt_fffffff9", 32'h4F80_0000, 32'hFFFF_FFFF, 2,  F_NV);
    endtask

    initial begin
        n_cmp            = 0;
        n_mis            = 0;
        rst              = 1'b1;
        bus.input_a      = 32'd0;
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b1;
        test_reset();
        test_shifted();
        test_specials();
        test_backpressure();
        test_reset_abort();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/float_to_unsig_int.md
Name: float_to_unsig_int

Overview:
- Multi-cycle converter from IEEE-754 single-precision float to unsigned 32-bit integer. It is the reverse direction of unsig_int_to_float.
- Serves FCVT.WU.S in the FPU datapath. Rounding is toward zero (RTZ).
- Uses the same stb/ack handshake style as the other float converters. One conversion is in flight at a time.

Parameters:
- none

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- input_a  input  32  float32 operand
- input_a_stb  input  1  operand valid
- input_a_ack  output  1  block ready; operand is accepted on an edge where input_a_stb && input_a_ack
- output_z  output  32  unsigned integer result
- output_z_stb  output  1  result valid
- output_z_ack  input  1  consumer accepts result

Behaviour:
- Reset: on any rst edge, including mid-conversion, go to GET_A.
  - input_a_ack=0, output_z_stb=0, output_z=0, internal regs cleared.
  - input_a_ack rises on the first edge after rst deasserts.
- All outputs are registered.
- FSM states:
  - GET_A: input_a_ack=1. On handshake (edge N) latch input_a, drop ack, go to UNPACK. input_a is ignored when no handshake occurs.
  - UNPACK (edge N+1): split sign s, exp[7:0], frac[22:0]. Go to SPECIAL.
  - SPECIAL (edge N+2): classify the operand, first match wins:
    - exp==255, frac!=0 (NaN): z=0xFFFFFFFF, NV. Go to PUT_Z.
    - exp==255, frac==0 (inf): +inf gives z=0xFFFFFFFF; -inf gives z=0. Both NV. Go to PUT_Z.
    - exp==0 (zero/denormal): z=0. NX if frac!=0. Go to PUT_Z.
    - s=1, exp>=127 (value <= -1.0): z=0, NV. Go to PUT_Z.
    - exp<127 (0 < |x| < 1): z=0, NX. Go to PUT_Z.
    - s=0, exp>158 (>= 2^32): z=0xFFFFFFFF, NV. Go to PUT_Z.
    - otherwise: m={1,frac,8'b0} (32 bits), e=exp-127 (0..31), sticky=0. Go to SHIFT.
  - SHIFT: per edge, while e<31:
    - m<=m>>1, e<=e+1, sticky|=m[0].
    - On the edge where e==31: z<=m, NX<=sticky, go to PUT_Z.
  - PUT_Z: output_z_stb=1; output_z and flags held stable.
    - On the edge with output_z_ack=1: stb drops, go to GET_A. input_a_ack rises on that same edge.
- Latency, measured from the accept edge N to output_z_stb visible:
  - special cases: after edge N+2
  - shifted cases: after edge N+3+(31-e), i.e. 3..34 cycles
- output_z_stb is never asserted while input_a_ack=1, and vice versa.
- output_z_ack held high before stb is harmless; the result is consumed on the first edge with stb=1.
- Back-to-back operation: a new operand can be accepted on the edge after result consumption.

Optional Feature:
- Macro FTOU_FFLAGS_EN.
- Defined:
  - Adds port output_flags, output, 5 bits, in RISC-V fflags order {NV,DZ,OF,UF,NX}.
  - Registered, valid while output_z_stb=1, cleared to 0 on reset and when a new operand is accepted.
  - DZ, OF and UF are always 0.
- Undefined: the port and all flag/sticky logic are absent. output_z and timing are identical.

Test Plan:
- 0x40000000 (2.0), consumer ack held high -> output_z=0x00000002, stb after edge N+33, flags=0. 0x4F7FFFFF -> 0xFFFFFF00 after edge N+3, flags=0.
- 0x3FC00000 (1.5) -> 0x00000001, NX=1. 0x3F000000 (0.5) -> 0, NX=1 after edge N+2. 0x00000001 (denormal) -> 0, NX=1. 0x80000000 -> 0, flags=0.
- 0x7FC00000 (NaN) -> 0xFFFFFFFF, NV. 0x4F800000 (2^32) -> 0xFFFFFFFF, NV. 0xFF800000 (-inf) -> 0, NV. 0xBF800000 (-1.0) -> 0, NV. 0xBF000000 (-0.5) -> 0, NX.
- Backpressure: output_z_ack low for 5 cycles after stb -> output_z/stb stable and input_a_ack=0 throughout. Raise ack -> stb drops and input_a_ack=1 on that edge. Next operand 0x40400000 -> 3.
- Reset: assert rst 10 cycles into SHIFT for 0x3F800001 -> next edge stb=0, ack=0, output_z=0. After release, 0x41200000 converts to 10 with no residue from the aborted operation.
- Round-trip: feed unsig_int_to_float results for 0x00000002 and 0x00FFFFFF back in -> original integers, flags=0. For 0xFFFFFFF9, the float rounds to 2^32, giving 0xFFFFFFFF with NV.
